// File: rtl/capture_demux.sv
// capture_demux: splits the merged capture stream into a forwarding stream (port 0) and a capture stream (port 1), routing whole packets by the duplicate flag in tuser.
// Optional macro CAPTURE_DROP_EN: capture packets whose SOP finds the output slot busy are discarded and counted in drop_cnt.
module capture_demux #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int DUP_FLAG_BIT       = 32
) (
    input  logic                            axi_aclk,
    input  logic                            axi_aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_0,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_0,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_0,
    output logic                            m_axis_tvalid_0,
    output logic                            m_axis_tlast_0,
    input  logic                            m_axis_tready_0,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata_1,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb_1,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser_1,
    output logic                            m_axis_tvalid_1,
    output logic                            m_axis_tlast_1,
    input  logic                            m_axis_tready_1,
    output logic [31:0]                     pkt_cnt_0,
    output logic [31:0]                     pkt_cnt_1,
    output logic [31:0]                     drop_cnt
);
    // state | meaning
    // IDLE  | next input beat is a start of packet; its flag picks the route
    // FWD   | inside a packet; beats follow the route latched at SOP
    // DROP  | inside a discarded capture packet (CAPTURE_DROP_EN only)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1
`ifdef CAPTURE_DROP_EN
        , DROP = 2'd2
`endif
    } state_t;

    state_t                          state_q, state_d;
    logic                            cur_dest_q, cur_dest_d;
    logic                            slot_valid_q, slot_valid_d;
    logic                            slot_dest_q, slot_dest_d;
    logic                            slot_last_q, slot_last_d;
    logic [C_AXIS_DATA_WIDTH-1:0]    slot_data_q, slot_data_d;
    logic [C_AXIS_DATA_WIDTH/8-1:0]  slot_strb_q, slot_strb_d;
    logic [C_AXIS_TUSER_WIDTH-1:0]   slot_user_q, slot_user_d;
    logic [31:0]                     pkt_cnt_0_q, pkt_cnt_0_d;
    logic [31:0]                     pkt_cnt_1_q, pkt_cnt_1_d;

    logic sel, dest_ready, drain, slot_free, discard, ready, accept, load;
    logic [C_AXIS_TUSER_WIDTH-1:0] user_clr;

    always_comb begin
        sel        = s_axis_tuser[DUP_FLAG_BIT];
        dest_ready = slot_dest_q ? m_axis_tready_1 : m_axis_tready_0;
        drain      = slot_valid_q & dest_ready;
        slot_free  = ~slot_valid_q | dest_ready;
        discard    = 1'b0;
        ready      = slot_free;
`ifdef CAPTURE_DROP_EN
        // A capture SOP that would stall is swallowed so forwarding never waits on the capture port.
        discard    = ((state_q == IDLE) & s_axis_tvalid & sel & ~slot_free) | (state_q == DROP);
        ready      = slot_free | discard;
`endif
        // Reset holds the input stalled regardless of slot state.
        s_axis_tready = axi_aresetn & ready;
        accept        = s_axis_tvalid & s_axis_tready;
        load          = accept & ~discard;

        user_clr               = s_axis_tuser;
        user_clr[DUP_FLAG_BIT] = 1'b0;

        state_d    = state_q;
        cur_dest_d = cur_dest_q;
        case (state_q)
            IDLE: begin
                if (load) cur_dest_d = sel;
                if (accept && !s_axis_tlast) begin
`ifdef CAPTURE_DROP_EN
                    state_d = discard ? DROP : FWD;
`else
                    state_d = FWD;
`endif
                end
            end
            FWD:     if (accept && s_axis_tlast) state_d = IDLE;
`ifdef CAPTURE_DROP_EN
            DROP:    if (accept && s_axis_tlast) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        slot_valid_d = slot_valid_q;
        slot_dest_d  = slot_dest_q;
        slot_last_d  = slot_last_q;
        slot_data_d  = slot_data_q;
        slot_strb_d  = slot_strb_q;
        slot_user_d  = slot_user_q;
        if (load) begin
            slot_valid_d = 1'b1;
            slot_dest_d  = (state_q == IDLE) ? sel : cur_dest_q;
            slot_last_d  = s_axis_tlast;
            slot_data_d  = s_axis_tdata;
            slot_strb_d  = s_axis_tstrb;
            slot_user_d  = user_clr;
        end else if (drain) begin
            slot_valid_d = 1'b0;
        end

        pkt_cnt_0_d = pkt_cnt_0_q + {31'd0, drain & slot_last_q & ~slot_dest_q};
        pkt_cnt_1_d = pkt_cnt_1_q + {31'd0, drain & slot_last_q & slot_dest_q};
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q      <= IDLE;
            cur_dest_q   <= 1'b0;
            slot_valid_q <= 1'b0;
            slot_dest_q  <= 1'b0;
            slot_last_q  <= 1'b0;
            slot_data_q  <= '0;
            slot_strb_q  <= '0;
            slot_user_q  <= '0;
            pkt_cnt_0_q  <= '0;
            pkt_cnt_1_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_dest_q   <= cur_dest_d;
            slot_valid_q <= slot_valid_d;
            slot_dest_q  <= slot_dest_d;
            slot_last_q  <= slot_last_d;
            slot_data_q  <= slot_data_d;
            slot_strb_q  <= slot_strb_d;
            slot_user_q  <= slot_user_d;
            pkt_cnt_0_q  <= pkt_cnt_0_d;
            pkt_cnt_1_q  <= pkt_cnt_1_d;
        end
    end

`ifdef CAPTURE_DROP_EN
    logic [31:0] drop_cnt_q, drop_cnt_d;

    always_comb drop_cnt_d = drop_cnt_q + {31'd0, accept & discard & (state_q == IDLE)};

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) drop_cnt_q <= '0;
        else              drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

    assign m_axis_tdata_0  = slot_data_q;
    assign m_axis_tstrb_0  = slot_strb_q;
    assign m_axis_tuser_0  = slot_user_q;
    assign m_axis_tlast_0  = slot_last_q;
    assign m_axis_tvalid_0 = slot_valid_q & ~slot_dest_q;
    assign m_axis_tdata_1  = slot_data_q;
    assign m_axis_tstrb_1  = slot_strb_q;
    assign m_axis_tuser_1  = slot_user_q;
    assign m_axis_tlast_1  = slot_last_q;
    assign m_axis_tvalid_1 = slot_valid_q & slot_dest_q;
    assign pkt_cnt_0       = pkt_cnt_0_q;
    assign pkt_cnt_1       = pkt_cnt_1_q;
endmodule

// File: tb/tb_capture_demux.sv
// Bench for capture_demux: packet table, cycle-level corner cases, and random packets checked against a packet-level scoreboard.
`timescale 1ns/1ps
module tb_capture_demux;
    localparam int DW  = 256;
    localparam int UW  = 128;
    localparam int SW  = DW / 8;
    localparam int DUP = 32;

    logic          axi_aclk        = 1'b0;
    logic          axi_aresetn     = 1'b0;
    logic [DW-1:0] s_axis_tdata    = '0;
    logic [SW-1:0] s_axis_tstrb    = '0;
    logic [UW-1:0] s_axis_tuser    = '0;
    logic          s_axis_tvalid   = 1'b0;
    logic          s_axis_tlast    = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata_0, m_axis_tdata_1;
    logic [SW-1:0] m_axis_tstrb_0, m_axis_tstrb_1;
    logic [UW-1:0] m_axis_tuser_0, m_axis_tuser_1;
    logic          m_axis_tvalid_0, m_axis_tvalid_1;
    logic          m_axis_tlast_0, m_axis_tlast_1;
    logic          m_axis_tready_0 = 1'b1;
    logic          m_axis_tready_1 = 1'b1;
    logic [31:0]   pkt_cnt_0, pkt_cnt_1, drop_cnt;

    always #5 axi_aclk = ~axi_aclk;

    capture_demux dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata_0(m_axis_tdata_0), .m_axis_tstrb_0(m_axis_tstrb_0), .m_axis_tuser_0(m_axis_tuser_0),
        .m_axis_tvalid_0(m_axis_tvalid_0), .m_axis_tlast_0(m_axis_tlast_0), .m_axis_tready_0(m_axis_tready_0),
        .m_axis_tdata_1(m_axis_tdata_1), .m_axis_tstrb_1(m_axis_tstrb_1), .m_axis_tuser_1(m_axis_tuser_1),
        .m_axis_tvalid_1(m_axis_tvalid_1), .m_axis_tlast_1(m_axis_tlast_1), .m_axis_tready_1(m_axis_tready_1),
        .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
        int            cyc;
    } beat_t;

    typedef struct {
        bit rst_before;
        bit flag;
        int len;
        int exp_c0;
        int exp_c1;
    } vec_t;

    beat_t exp0[$];
    beat_t exp1[$];
    int    n_chk = 0, n_fail = 0;
    int    cyc = 0;
    bit    chk_lat = 1'b0;
    bit    rnd_rdy = 1'b0;
    int    mc0 = 0, mc1 = 0;

    always @(posedge axi_aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [UW-1:0] rnd_user();
        logic [UW-1:0] r;
        for (int i = 0; i < UW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic cmp_beat(input string p, input beat_t e, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input logic [UW-1:0] u, input logic l);
        check({p, "_data"}, d, e.data);
        check({p, "_strb"}, s, e.strb);
        check({p, "_user"}, u, e.user);
        check({p, "_last"}, l, e.last);
        if (chk_lat) check({p, "_latency"}, cyc, e.cyc + 1);
    endtask

    // Output monitor, sampled one time unit before each rising edge.
    logic          st0 = 1'b0, st1 = 1'b0;
    logic [DW-1:0] hd0, hd1;
    always begin
        @(negedge axi_aclk);
        #4;
        if (!axi_aresetn) begin
            st0 = 1'b0;
            st1 = 1'b0;
        end else begin
            if (m_axis_tvalid_0 || m_axis_tvalid_1)
                check("valid_onehot", m_axis_tvalid_0 & m_axis_tvalid_1, 1'b0);
`ifndef CAPTURE_DROP_EN
            check("s_ready_vs_slot_free", s_axis_tready,
                  !(m_axis_tvalid_0 || m_axis_tvalid_1) || (m_axis_tvalid_0 && m_axis_tready_0)
                  || (m_axis_tvalid_1 && m_axis_tready_1));
`endif
            if (st0) begin
                check("hold_valid_0", m_axis_tvalid_0, 1'b1);
                check("hold_data_0", m_axis_tdata_0, hd0);
            end
            if (st1) begin
                check("hold_valid_1", m_axis_tvalid_1, 1'b1);
                check("hold_data_1", m_axis_tdata_1, hd1);
            end
            if (m_axis_tvalid_0 && m_axis_tready_0) begin
                check("p0_beat_expected", exp0.size() != 0, 1'b1);
                if (exp0.size() != 0)
                    cmp_beat("p0", exp0.pop_front(), m_axis_tdata_0, m_axis_tstrb_0, m_axis_tuser_0, m_axis_tlast_0);
            end
            if (m_axis_tvalid_1 && m_axis_tready_1) begin
                check("p1_beat_expected", exp1.size() != 0, 1'b1);
                if (exp1.size() != 0)
                    cmp_beat("p1", exp1.pop_front(), m_axis_tdata_1, m_axis_tstrb_1, m_axis_tuser_1, m_axis_tlast_1);
            end
            st0 = m_axis_tvalid_0 && !m_axis_tready_0;
            st1 = m_axis_tvalid_1 && !m_axis_tready_1;
            hd0 = m_axis_tdata_0;
            hd1 = m_axis_tdata_1;
        end
    end

    always @(negedge axi_aclk) begin
        if (rnd_rdy) begin
            m_axis_tready_0 = ($urandom_range(0, 3) != 0);
            m_axis_tready_1 = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at a falling edge; returns at the falling edge after the beat is accepted.
    task automatic send_beat(input beat_t b, input int port, input bit expect_out, output int waits);
        s_axis_tdata  = b.data;
        s_axis_tstrb  = b.strb;
        s_axis_tuser  = b.user;
        s_axis_tlast  = b.last;
        s_axis_tvalid = 1'b1;
        waits = 0;
        #4;
        while (!s_axis_tready && waits <= 2000) begin
            @(negedge axi_aclk);
            #4;
            waits++;
        end
        if (!s_axis_tready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: s_axis_tready=%0b after %0d cycles, expected 1", s_axis_tready, waits);
        end else if (expect_out) begin
            b.cyc = cyc;
            b.user[DUP] = 1'b0;
            if (port == 1) exp1.push_back(b);
            else           exp0.push_back(b);
        end
        @(negedge axi_aclk);
    endtask

    // Only the first beat's flag decides the route; later beats carry random flags.
    task automatic send_pkt(input bit flag, input int len, input bit expect_out, output int waits_sum);
        int w;
        waits_sum = 0;
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.data = rnd_data();
            b.strb = SW'($urandom);
            b.user = rnd_user();
            if (i == 0) b.user[DUP] = flag;
            b.last = (i == len - 1);
            b.cyc  = 0;
            send_beat(b, int'(flag), expect_out, w);
            waits_sum += w;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (expect_out) begin
            if (flag) mc1++;
            else      mc0++;
        end
    endtask

    task automatic do_reset();
        check("queues_empty_before_reset", exp0.size() + exp1.size(), 0);
        axi_aresetn = 1'b0;
        exp0.delete();
        exp1.delete();
        mc0 = 0;
        mc1 = 0;
        repeat (2) @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pkt_cnt_0"}, pkt_cnt_0, mc0);
        check({tag, "_pkt_cnt_1"}, pkt_cnt_1, mc1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, n_chk=%0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[10];
        int   w, w2;
        beat_t b;

        vt[0] = '{1, 0, 3, 1, 0};
        vt[1] = '{0, 1, 3, 1, 1};
        vt[2] = '{0, 0, 3, 2, 1};
        vt[3] = '{0, 1, 3, 2, 2};
        vt[4] = '{0, 0, 3, 3, 2};
        vt[5] = '{0, 1, 3, 3, 3};
        vt[6] = '{1, 1, 1, 0, 1};
        vt[7] = '{0, 0, 1, 1, 1};
        vt[8] = '{0, 0, 1, 2, 1};
        vt[9] = '{0, 1, 1, 2, 2};

        // Reset state
        repeat (2) @(negedge axi_aclk);
        #1;
        check("rst_tvalid_0", m_axis_tvalid_0, 1'b0);
        check("rst_tvalid_1", m_axis_tvalid_1, 1'b0);
        check("rst_s_tready", s_axis_tready, 1'b0);
        check("rst_pkt_cnt_0", pkt_cnt_0, 0);
        check("rst_pkt_cnt_1", pkt_cnt_1, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_tdata", m_axis_tdata_0, 0);
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);

        // Packet table: routing, latency, counts
        chk_lat = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (vt[i].rst_before) do_reset();
            send_pkt(vt[i].flag, vt[i].len, 1'b1, w);
            check("tbl_no_bubble", w, 0);
            @(negedge axi_aclk);
            #4;
            check("tbl_pkt_cnt_0", pkt_cnt_0, vt[i].exp_c0);
            check("tbl_pkt_cnt_1", pkt_cnt_1, vt[i].exp_c1);
            @(negedge axi_aclk);
        end
        check("tbl_drop_cnt", drop_cnt, 0);

        // Port-0 packet with tready_0 toggling 1,0,1,0
        chk_lat = 1'b0;
        fork
            send_pkt(1'b0, 4, 1'b1, w);
            for (int k = 0; k < 10; k++) begin
                m_axis_tready_0 = (k % 2 == 0);
                @(negedge axi_aclk);
            end
        join
        m_axis_tready_0 = 1'b1;
        repeat (2) @(negedge axi_aclk);
        check_counts("toggle");

        // Capture port stalled with a parked capture beat, then a 5-beat capture packet
        m_axis_tready_1 = 1'b0;
        send_pkt(1'b1, 1, 1'b1, w);
        @(negedge axi_aclk);
        #4;
        check("cap_parked_valid", m_axis_tvalid_1, 1'b1);
        @(negedge axi_aclk);
`ifdef CAPTURE_DROP_EN
        send_pkt(1'b1, 5, 1'b0, w);
        check("drop_consumed_no_wait", w, 0);
        #4;
        check("drop_cnt", drop_cnt, 1);
        check("drop_parked_still", m_axis_tvalid_1, 1'b1);
        @(negedge axi_aclk);
        m_axis_tready_1 = 1'b1;
        send_pkt(1'b0, 2, 1'b1, w);
`else
        fork
            send_pkt(1'b1, 5, 1'b1, w);
            begin
                for (int k = 0; k < 6; k++) begin
                    #4;
                    check("cap_stall_s_ready", s_axis_tready, 1'b0);
                    check("cap_stall_p0_idle", m_axis_tvalid_0, 1'b0);
                    @(negedge axi_aclk);
                end
                m_axis_tready_1 = 1'b1;
            end
        join
        check("cap_stall_waited", w >= 6, 1'b1);
        check("cap_drop_cnt_zero", drop_cnt, 0);
`endif
        repeat (3) @(negedge axi_aclk);
        check_counts("capture");

        // Random packets against the scoreboard
`ifndef CAPTURE_DROP_EN
        rnd_rdy = 1'b1;
`endif
        for (int p = 0; p < 120; p++) begin
            send_pkt(1'($urandom_range(0, 1)), $urandom_range(1, 6), 1'b1, w);
            repeat ($urandom_range(0, 2)) @(negedge axi_aclk);
        end
        rnd_rdy = 1'b0;
        m_axis_tready_0 = 1'b1;
        m_axis_tready_1 = 1'b1;
        for (int k = 0; k < 200 && (exp0.size() + exp1.size()) != 0; k++) @(negedge axi_aclk);
        repeat (2) @(negedge axi_aclk);
        check("rnd_drained", exp0.size() + exp1.size(), 0);
        check_counts("rnd");

        // Reset asserted while beat 2 of a 4-beat port-0 packet is presented
        chk_lat = 1'b1;
        b.data = rnd_data(); b.strb = SW'($urandom); b.user = rnd_user(); b.user[DUP] = 1'b0; b.last = 1'b0; b.cyc = 0;
        send_beat(b, 0, 1'b1, w);
        s_axis_tdata = rnd_data();
        s_axis_tuser = rnd_user();
        s_axis_tlast = 1'b0;
        #1;
        axi_aresetn = 1'b0;
        #1;
        check("mid_rst_tvalid_0", m_axis_tvalid_0, 1'b0);
        check("mid_rst_tvalid_1", m_axis_tvalid_1, 1'b0);
        check("mid_rst_s_tready", s_axis_tready, 1'b0);
        check("mid_rst_pkt_cnt_0", pkt_cnt_0, 0);
        check("mid_rst_pkt_cnt_1", pkt_cnt_1, 0);
        exp0.delete();
        exp1.delete();
        mc0 = 0;
        mc1 = 0;
        @(negedge axi_aclk);
        s_axis_tvalid = 1'b0;
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        b.data = rnd_data(); b.strb = SW'($urandom); b.user = rnd_user(); b.user[DUP] = 1'b1; b.last = 1'b0;
        send_beat(b, 1, 1'b1, w);
        b.data = rnd_data(); b.strb = SW'($urandom); b.user = rnd_user(); b.user[DUP] = 1'b0; b.last = 1'b1;
        send_beat(b, 1, 1'b1, w2);
        s_axis_tvalid = 1'b0;
        mc1 = 1;
        @(negedge axi_aclk);
        #4;
        check_counts("post_rst");
        check("post_rst_no_bubble", w + w2, 0);
        @(negedge axi_aclk);
        check("final_queues_empty", exp0.size() + exp1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
